// File: rtl/uart_tx_arb.sv
// Four-requester round-robin arbiter that feeds whole frames, one byte at a time, into a single UART TX.
// Optional grant-hold timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ack,
    output logic [3:0]  grant,
    input  logic        tx_empty,
    output logic        tx_latch,
    output logic [7:0]  tx_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        WAIT_BUSY = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  owner_q;
    logic        last_q;
    logic [3:0]  grant_q;
    logic [3:0]  req_ack_q;
    logic        tx_latch_q;
    logic [7:0]  tx_data_q;
    logic [1:0]  pick_d;
    logic [7:0]  owner_byte;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        timeout_err_q;
`endif

    // Scan downward so the requester closest after ptr_q wins; k=4 wraps to ptr_q itself.
    always_comb begin
        pick_d = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                pick_d = ptr_q + 2'(k);
            end
        end
    end

    assign owner_byte = req_data[{owner_q, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            owner_q    <= 2'd0;
            last_q     <= 1'b0;
            grant_q    <= 4'b0000;
            req_ack_q  <= 4'b0000;
            tx_latch_q <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_cnt_q     <= 16'd0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            req_ack_q  <= 4'b0000;
            tx_latch_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_q <= 16'd0;
`endif
                    if (|req) begin
                        owner_q <= pick_d;
                        grant_q <= 4'b0001 << pick_d;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[owner_q]) begin
                        if (tx_empty) begin
                            tx_latch_q         <= 1'b1;
                            tx_data_q          <= owner_byte;
                            req_ack_q[owner_q] <= 1'b1;
                            last_q             <= req_last[owner_q];
                            state_q            <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                            tmo_cnt_q          <= 16'd0;
`endif
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == TIMEOUT - 16'd1) begin
                        timeout_err_q <= 1'b1;
                        grant_q       <= 4'b0000;
                        ptr_q         <= owner_q;
                        tmo_cnt_q     <= 16'd0;
                        state_q       <= IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
`endif
                end
                WAIT_BUSY: begin
`ifdef UART_ARB_TIMEOUT_EN
                    tmo_cnt_q <= 16'd0;
`endif
                    // Wait for the UART's own busy indication before offering another byte.
                    if (!tx_empty) begin
                        if (last_q) begin
                            grant_q <= 4'b0000;
                            ptr_q   <= owner_q;
                            state_q <= IDLE;
                        end else begin
                            state_q <= GRANT;
                        end
                    end
                end
                default: begin
                    grant_q <= 4'b0000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign req_ack  = req_ack_q;
    assign tx_latch = tx_latch_q;
    assign tx_data  = tx_data_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

endmodule
